// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op codes, FSM states and
// the width of the bit-step counter.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    // Counter must hold the value N itself, hence one bit above clog2.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/twos_abs.sv
// Conditional two's-complement negate: used both to take operand magnitudes
// and to restore result signs. Purely combinational.
module twos_abs #(
    parameter int N = 8
) (
    input  logic [N-1:0] val_i,
    input  logic         neg_i,
    output logic [N-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + N'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with its own HI/LO pair.
// One bit per cycle: N+1 busy cycles, then a one-cycle done pulse with HI/LO updated.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] srca,
    input  logic [N-1:0] srcb,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wd,
    input  logic         hilo_rd,
    output logic [N-1:0] HI,
    output logic [N-1:0] LO,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic         stall
);

    localparam int CW = cnt_width(N);

    md_state_e       state_q, state_d;
    md_op_e          op_q, op_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            bz_q, bz_d;
    logic [N-1:0]    opa_q, opa_d;
    logic [N-1:0]    sh_q, sh_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    dvd_q, dvd_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dz_q, dz_d;

    logic            sign_a, sign_b, is_div;
    logic [N-1:0]    a_mag, b_mag;
    logic [N-1:0]    quot_fix, rem_fix;
    logic [2*N-1:0]  prod_fix;
    logic [N:0]      mul_sum, rem_sh, trial;

    assign sign_a = ~op[0] & srca[N-1];
    assign sign_b = ~op[0] & srcb[N-1];
    assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);

    twos_abs #(.N(N)) u_abs_a (.val_i(srca), .neg_i(sign_a), .res_o(a_mag));
    twos_abs #(.N(N)) u_abs_b (.val_i(srcb), .neg_i(sign_b), .res_o(b_mag));

    twos_abs #(.N(2*N)) u_fix_prod (.val_i({acc_q, sh_q}), .neg_i(neg_res_q), .res_o(prod_fix));
    twos_abs #(.N(N))   u_fix_quot (.val_i(sh_q),  .neg_i(neg_res_q), .res_o(quot_fix));
    twos_abs #(.N(N))   u_fix_rem  (.val_i(acc_q), .neg_i(neg_rem_q), .res_o(rem_fix));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        bz_d      = bz_q;
        opa_d     = opa_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        dvd_d     = dvd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;

        mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opa_q} : '0);
        rem_sh  = {acc_q, sh_q[N-1]};
        trial   = rem_sh - {1'b0, opa_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = md_op_e'(op);
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    bz_d      = (srcb == '0);
                    dvd_d     = srca;
                    // Multiply keeps the multiplier in the shift register;
                    // divide keeps the dividend there so quotient bits shift in.
                    opa_d     = op[1] ? b_mag : a_mag;
                    sh_d      = op[1] ? a_mag : b_mag;
                    acc_d     = '0;
                    cnt_d     = CW'(N);
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
            CALC: begin
                if (is_div) begin
                    if (!trial[N]) begin
                        acc_d = trial[N-1:0];
                        sh_d  = {sh_q[N-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[N-1:0];
                        sh_d  = {sh_q[N-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[N:1];
                    sh_d  = {mul_sum[0], sh_q[N-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                // Most-negative / -1 needs no special case: the magnitude
                // quotient 2^(N-1) negates back onto itself with remainder 0.
                if (is_div) begin
                    if (bz_q) begin
                        lo_d = '1;
                        hi_d = dvd_q;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                dz_d    = is_div & bz_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            op_q      <= MD_MULT;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bz_q      <= 1'b0;
            opa_q     <= '0;
            sh_q      <= '0;
            acc_q     <= '0;
            dvd_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            bz_q      <= bz_d;
            opa_q     <= opa_d;
            sh_q      <= sh_d;
            acc_q     <= acc_d;
            dvd_q     <= dvd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign HI       = hi_q;
    assign LO       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign stall    = busy_q & (start | hi_we | lo_we | hilo_rd);

endmodule
